// File: rtl/fifo_drain_pkg.sv
// fifo_drain_pkg: shared FSM state type and fixed geometry of the FIFO drain stage
package fifo_drain_pkg;
   typedef enum logic [1:0] {IDLE, FETCH, STALL} drain_state_e;
   localparam int SKID_DEPTH = 2;
   localparam int RD_LATENCY = 1;
endpackage

// File: rtl/fifo_drain_ctrl_if.sv
// fifo_drain_ctrl_if: FIFO read port plus valid/ready output stream of the drain stage
interface fifo_drain_ctrl_if #(parameter int DATA_WIDTH = 16);
   logic [DATA_WIDTH-1:0] fifo_dout;
   logic                  fifo_empty;
   logic                  fifo_almostempty;
   logic                  fifo_underflow;
   logic                  fifo_rd_en;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_valid;
   logic                  m_ready;
   modport master (
      input  fifo_dout, fifo_empty, fifo_almostempty, fifo_underflow, m_ready,
      output fifo_rd_en, m_data, m_valid
   );
   modport slave (
      output fifo_dout, fifo_empty, fifo_almostempty, fifo_underflow, m_ready,
      input  fifo_rd_en, m_data, m_valid
   );
endinterface

// File: rtl/fifo_skid_buf.sv
// fifo_skid_buf: 2-entry circular skid buffer holding captured FIFO read data
module fifo_skid_buf
   import fifo_drain_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_i,
   input  logic                  pop_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic [1:0]            occ_o
);
   logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
   logic                  head_q;
   logic                  tail_q;
   logic [1:0]            occ_q;

   assign data_o = mem_q[head_q];
   assign occ_o  = occ_q;

   // storage, wrapping pointers and occupancy; push and pop in one cycle leave occ unchanged
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
         head_q <= 1'b0;
         tail_q <= 1'b0;
         occ_q  <= 2'd0;
      end else begin
         if (push_i) begin
            mem_q[tail_q] <= data_i;
            tail_q        <= !tail_q;
         end
         if (pop_i) head_q <= !head_q;
         occ_q <= occ_q + {1'b0, push_i} - {1'b0, pop_i};
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push_i && !pop_i && occ_q == 2'd2));
endmodule

// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl: issues underflow-safe FIFO reads into a skid buffer and streams them out;
// optional stall/starve statistics counters are built when FIFO_DRAIN_STATS_EN is defined
module fifo_drain_ctrl
   import fifo_drain_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   fifo_drain_ctrl_if.master    bus,
   output logic [CNT_WIDTH-1:0] drain_cnt,
   output logic                 err_underflow
`ifdef FIFO_DRAIN_STATS_EN
   ,
   output logic [CNT_WIDTH-1:0] stall_cycles,
   output logic [CNT_WIDTH-1:0] starve_cycles
`endif
);
   drain_state_e         state_q;
   logic                 inflight_q;
   logic                 ae_rd_q;
   logic                 err_q;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic [1:0]           occ;
   logic [2:0]           fill;
   logic                 pop;
   logic                 push;
   logic                 room;
   logic                 rd_en;

   assign pop           = bus.m_valid && bus.m_ready;
   assign push          = inflight_q && !bus.fifo_underflow;
   assign fill          = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};
   assign room          = fill < 3'd2;
   // ae_rd_q blocks a read right after taking the last word, before fifo_empty can follow
   assign rd_en         = !rst && !bus.fifo_empty && room && !ae_rd_q &&
                          (state_q == FETCH || state_q == IDLE);
   assign bus.fifo_rd_en = rd_en;
   assign bus.m_valid   = occ != 2'd0;
   assign drain_cnt     = cnt_q;
   assign err_underflow = err_q;

   fifo_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
      .clk    (clk),
      .rst    (rst),
      .push_i (push),
      .pop_i  (pop),
      .data_i (bus.fifo_dout),
      .data_o (bus.m_data),
      .occ_o  (occ)
   );

   // status FSM: idle when everything is drained, stall while the buffer is full and blocked
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else begin
         case (state_q)
            IDLE:    state_q <= !bus.fifo_empty ? FETCH : IDLE;
            FETCH:   state_q <= (!bus.fifo_empty && !room && !bus.m_ready) ? STALL :
                                (bus.fifo_empty && occ == 2'd0 && !inflight_q) ? IDLE : FETCH;
            STALL:   state_q <= pop ? FETCH : STALL;
            default: state_q <= IDLE;
         endcase
      end
   end

   // read tracking, drained-word counter and sticky underflow flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight_q <= 1'b0;
         ae_rd_q    <= 1'b0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
      end else begin
         inflight_q <= rd_en;
         ae_rd_q    <= rd_en && bus.fifo_almostempty;
         err_q      <= err_q || (inflight_q && bus.fifo_underflow);
         cnt_q      <= pop ? cnt_q + 1'b1 : cnt_q;
      end
   end

`ifdef FIFO_DRAIN_STATS_EN
   logic [CNT_WIDTH-1:0] stall_q;
   logic [CNT_WIDTH-1:0] starve_q;

   assign stall_cycles  = stall_q;
   assign starve_cycles = starve_q;

   // saturating counts of backpressured cycles and of starved cycles with data still queued
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q  <= '0;
         starve_q <= '0;
      end else begin
         stall_q  <= (bus.m_valid && !bus.m_ready && !(&stall_q)) ? stall_q + 1'b1 : stall_q;
         starve_q <= (bus.m_ready && !bus.m_valid && !bus.fifo_empty && !(&starve_q)) ?
                     starve_q + 1'b1 : starve_q;
      end
   end
`endif
endmodule
